// File: rtl/uart_pkg.sv
// Shared types and helpers for the debug-link UART blocks: receiver state encoding,
// byte type and bit-timing arithmetic.
package uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Centre of a bit period; the majority vote uses mid-1, mid and mid+1.
  function automatic int calc_mid(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// First-word-fall-through byte FIFO, single clock. The head byte is held in a register
// that is refilled from the array on pop, so the array only ever sees a registered read.
module sync_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  byte_t                  push_data,
  input  logic                   pop,
  output byte_t                  head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW + 1)'(1);

  byte_t          mem [DEPTH];
  logic  [AW-1:0] wr_ptr_q;
  logic  [AW-1:0] rd_ptr_q;
  logic  [AW-1:0] rd_ptr_next;
  logic  [AW:0]   count_q;
  byte_t          head_q;
  logic           do_pop;
  logic           do_push;

  assign empty       = (count_q == '0);
  assign full        = (count_q == FULL_CNT);
  assign do_pop      = pop && !empty;
  // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
  assign do_push     = push && (!full || do_pop);
  assign rd_ptr_next = rd_ptr_q + AW'(1);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_next;
      end

      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + ONE_CNT;
        2'b01:   count_q <= count_q - ONE_CNT;
        default: count_q <= count_q;
      endcase

      // The incoming byte becomes head when nothing older will remain after this cycle.
      if (do_push && (empty || (do_pop && count_q == ONE_CNT))) begin
        head_q <= push_data;
      end else if (do_pop && count_q > ONE_CNT) begin
        head_q <= mem[rd_ptr_next];
      end
    end
  end

  assign head  = head_q;
  assign count = count_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// Host-to-board UART receiver: synchronizes rx, deframes 8N1 bytes and queues them for
// the command consumer. Define UART_CMD_RX_PARITY_EN for 8O1 framing with a parity_err pulse.
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 12000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD),
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        uart_rx,
  output byte_t                       rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        frame_err,
  output logic                        overrun,
`ifdef UART_CMD_RX_PARITY_EN
  output logic                        parity_err,
`endif
  output logic                        busy
);

  localparam int MID = calc_mid(CLKS_PER_BIT);
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] SMP_A    = CW'(MID - 1);
  localparam logic [CW-1:0] SMP_B    = CW'(MID);
  localparam logic [CW-1:0] SMP_C    = CW'(MID + 1);

  logic          meta_q;
  logic          sync_q;
  logic          prev_q;
  logic [2:0]    warm_q;
  logic          smp_a_q;
  logic          smp_b_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  byte_t         shift_q, shift_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
`ifdef UART_CMD_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
  logic          parity_err_q, parity_err_d;
`endif

  logic          maj;
  logic          at_smp;
  logic          at_wrap;
  logic          fall;
  logic          push_req;
  logic          fifo_empty;
  logic          fifo_full;

  // warm_q blocks edge detection until meta, sync and prev all hold real line values,
  // so a line that is already low when reset releases is not taken as a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      warm_q  <= '0;
      smp_a_q <= 1'b1;
      smp_b_q <= 1'b1;
    end else begin
      meta_q <= uart_rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
      warm_q <= {warm_q[1:0], 1'b1};
      if (cnt_q == SMP_A) begin
        smp_a_q <= sync_q;
      end
      if (cnt_q == SMP_B) begin
        smp_b_q <= sync_q;
      end
    end
  end

  assign maj     = (smp_a_q & smp_b_q) | (smp_a_q & sync_q) | (smp_b_q & sync_q);
  assign at_smp  = (cnt_q == SMP_C);
  assign at_wrap = (cnt_q == CNT_LAST);
  assign fall    = warm_q[2] & prev_q & ~sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_CMD_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = at_wrap ? '0 : cnt_q + CW'(1);
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    frame_err_d  = 1'b0;
    push_req     = 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = START;
        end
      end
      START: begin
        if (at_smp && maj) begin
          state_d = IDLE;
        end else if (at_wrap) begin
          state_d   = DATA;
          bit_idx_d = '0;
`ifdef UART_CMD_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      DATA: begin
        if (at_smp) begin
          shift_d = {maj, shift_q[7:1]};
        end
        if (at_wrap) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_CMD_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_CMD_RX_PARITY_EN
      PARITY: begin
        if (at_smp && !(^{shift_q, maj})) begin
          parity_err_d = 1'b1;
          par_bad_d    = 1'b1;
        end
        if (at_wrap) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (at_smp) begin
          if (maj) begin
            // Leaving at mid-stop lets the next start edge be caught half a bit early.
`ifdef UART_CMD_RX_PARITY_EN
            push_req = !par_bad_q;
`else
            push_req = 1'b1;
`endif
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
            cnt_d       = '0;
          end
        end
      end
      BREAK: begin
        if (!sync_q) begin
          cnt_d = '0;
        end else if (at_wrap) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A full FIFO only takes the byte if the consumer pops in the same cycle.
  assign overrun_d = push_req && fifo_full && !rx_ready;

  sync_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_req),
    .push_data(shift_q),
    .pop      (rx_ready),
    .head     (rx_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (rx_count)
  );

  assign rx_valid   = !fifo_empty;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);
`ifdef UART_CMD_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule
